axi_lite_master: RTL and testbench

AXI4-Lite initiator that turns a simple one-request-at-a-time command interface into AXI4-Lite read and write transactions and returns the response. It sits between the core or test logic and `mem_ctrl`, and drives that block's slave channels directly. At most one transaction is outstanding.

---
 rtl/axi_lite_pkg.sv | 18 +
 rtl/axi_lite_master.sv | 151 +++++++++++++++
 tb/tb_axi_lite_master.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and the initiator state encoding.
package axi_lite_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR_ADDR_DATA,
      ST_WR_RESP,
      ST_RD_ADDR,
      ST_RD_DATA,
      ST_RESP
   } state_t;

endpackage

// File: rtl/axi_lite_master.sv
// AXI4-Lite initiator: one command at a time in, one AW/W/B or AR/R transaction out.
// Latency: 3 cycles accept-to-rsp_valid with a zero-wait slave, plus any slave stall.
// Backpressure: req_ready only in IDLE; rsp_* held until rsp_ready; AXI valids hold until handshake.
module axi_lite_master
   import axi_lite_pkg::*;
#(
   parameter int WIDTH_P = 32
) (
   input  logic               ACLK,
   input  logic               ARESET,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic               req_we,
   input  logic [WIDTH_P-1:0] req_addr,
   input  logic [WIDTH_P-1:0] req_wdata,
   input  logic [3:0]         req_wstrb,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [WIDTH_P-1:0] rsp_rdata,
   output logic [1:0]         rsp_resp,
   output logic               rsp_we,
   output logic [WIDTH_P-1:0] M_AWADDR,
   output logic               M_AWVALID,
   input  logic               M_AWREADY,
   output logic [WIDTH_P-1:0] M_WDATA,
   output logic [3:0]         M_WSTRB,
   output logic               M_WVALID,
   input  logic               M_WREADY,
   input  logic [1:0]         M_BRESP,
   input  logic               M_BVALID,
   output logic               M_BREADY,
   output logic [WIDTH_P-1:0] M_ARADDR,
   output logic               M_ARVALID,
   input  logic               M_ARREADY,
   input  logic [WIDTH_P-1:0] M_RDATA,
   input  logic [1:0]         M_RRESP,
   input  logic               M_RVALID,
   output logic               M_RREADY
);

   state_t state;
   state_t state_nxt;
   logic   aw_done;
   logic   w_done;
   logic   aw_fire;
   logic   w_fire;
   logic   ar_fire;

   assign aw_fire = M_AWVALID & M_AWREADY;
   assign w_fire  = M_WVALID & M_WREADY;
   assign ar_fire = M_ARVALID & M_ARREADY;

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // AW and W may finish in either order; leave once both are done or firing now.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:         if (req_valid) state_nxt = req_we ? ST_WR_ADDR_DATA : ST_RD_ADDR;
         ST_WR_ADDR_DATA: if ((aw_done | aw_fire) && (w_done | w_fire)) state_nxt = ST_WR_RESP;
         ST_WR_RESP:      if (M_BVALID) state_nxt = ST_RESP;
         ST_RD_ADDR:      if (ar_fire) state_nxt = ST_RD_DATA;
         ST_RD_DATA:      if (M_RVALID) state_nxt = ST_RESP;
         ST_RESP:         if (rsp_ready) state_nxt = ST_IDLE;
         default:         state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      req_ready = (state == ST_IDLE);
      M_BREADY  = (state == ST_WR_RESP);
      M_RREADY  = (state == ST_RD_DATA);
   end

   // The M_* address/data/strobe registers double as the request holding registers.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         M_AWADDR  <= '0;
         M_AWVALID <= 1'b0;
         M_WDATA   <= '0;
         M_WSTRB   <= '0;
         M_WVALID  <= 1'b0;
         M_ARADDR  <= '0;
         M_ARVALID <= 1'b0;
         aw_done   <= 1'b0;
         w_done    <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_resp  <= '0;
         rsp_we    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  rsp_we <= req_we;
                  if (req_we) begin
                     M_AWADDR  <= req_addr;
                     M_WDATA   <= req_wdata;
                     M_WSTRB   <= req_wstrb;
                     M_AWVALID <= 1'b1;
                     M_WVALID  <= 1'b1;
                     aw_done   <= 1'b0;
                     w_done    <= 1'b0;
                  end else begin
                     M_ARADDR  <= req_addr;
                     M_ARVALID <= 1'b1;
                  end
               end
            end
            ST_WR_ADDR_DATA: begin
               if (aw_fire) begin
                  M_AWVALID <= 1'b0;
                  aw_done   <= 1'b1;
               end
               if (w_fire) begin
                  M_WVALID <= 1'b0;
                  w_done   <= 1'b1;
               end
            end
            ST_WR_RESP: begin
               if (M_BVALID) begin
                  rsp_resp  <= M_BRESP;
                  rsp_rdata <= '0;
                  rsp_valid <= 1'b1;
               end
            end
            ST_RD_ADDR: begin
               if (ar_fire) M_ARVALID <= 1'b0;
            end
            ST_RD_DATA: begin
               if (M_RVALID) begin
                  rsp_rdata <= M_RDATA;
                  rsp_resp  <= M_RRESP;
                  rsp_valid <= 1'b1;
               end
            end
            ST_RESP: begin
               if (rsp_ready) rsp_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_lite_master.sv
// Randomized bench for axi_lite_master: a delay-configurable AXI4-Lite slave plus a
// transaction-level model of expected response, latency and handshake counts.
module tb_axi_lite_master;
   import axi_lite_pkg::*;

   logic        ACLK = 1'b0;
   logic        ARESET;
   logic        req_valid, req_ready, req_we;
   logic [31:0] req_addr, req_wdata;
   logic [3:0]  req_wstrb;
   logic        rsp_valid, rsp_ready, rsp_we;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;
   logic [31:0] M_AWADDR, M_WDATA, M_ARADDR, M_RDATA;
   logic        M_AWVALID, M_AWREADY, M_WVALID, M_WREADY;
   logic [3:0]  M_WSTRB;
   logic [1:0]  M_BRESP, M_RRESP;
   logic        M_BVALID, M_BREADY, M_ARVALID, M_ARREADY, M_RVALID, M_RREADY;

   axi_lite_master #(.WIDTH_P(32)) dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_resp(rsp_resp), .rsp_we(rsp_we),
      .M_AWADDR(M_AWADDR), .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
      .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WVALID(M_WVALID), .M_WREADY(M_WREADY),
      .M_BRESP(M_BRESP), .M_BVALID(M_BVALID), .M_BREADY(M_BREADY),
      .M_ARADDR(M_ARADDR), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
      .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RVALID(M_RVALID), .M_RREADY(M_RREADY)
   );

   always #5 ACLK = ~ACLK;

   int tests = 0;
   int fails = 0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // slave configuration
   int          aw_dly, w_dly, ar_dly, b_dly, r_dly;
   logic [1:0]  b_resp_cfg, r_resp_cfg;
   logic [31:0] r_data_cfg;
   bit          slv_rst;

   // slave observations
   int          aw_cnt, w_cnt, ar_cnt, proto_err;
   logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
   logic [3:0]  cap_wstrb;

   // slave: decides readies/valids just after each falling edge
   initial begin : slave
      int aw_wait, w_wait, ar_wait, b_wait, r_wait;
      bit aw_seen, w_seen, ar_seen, b_pend, r_pend;
      logic p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
      logic [31:0] p_awaddr, p_wdata, p_araddr;
      logic [3:0] p_wstrb;
      aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
      aw_seen = 0; w_seen = 0; ar_seen = 0; b_pend = 0; r_pend = 0;
      p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_arv = 0; p_arr = 0;
      p_awaddr = 0; p_wdata = 0; p_araddr = 0; p_wstrb = 0;
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0; proto_err = 0;
      cap_awaddr = 0; cap_wdata = 0; cap_araddr = 0; cap_wstrb = 0;
      M_AWREADY = 0; M_WREADY = 0; M_ARREADY = 0;
      M_BVALID = 0; M_BRESP = 0; M_RVALID = 0; M_RDATA = 0; M_RRESP = 0;
      forever begin
         @(negedge ACLK);
         #1;
         if (slv_rst) begin
            aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
            aw_seen = 0; w_seen = 0; ar_seen = 0; b_pend = 0; r_pend = 0;
            M_AWREADY = 0; M_WREADY = 0; M_ARREADY = 0; M_BVALID = 0; M_RVALID = 0;
            p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_arv = 0; p_arr = 0;
         end else begin
            // a stalled valid must hold with stable payload; a completed one must drop
            if (p_awv && !p_awr && (!M_AWVALID || M_AWADDR !== p_awaddr)) proto_err++;
            if (p_wv && !p_wr && (!M_WVALID || M_WDATA !== p_wdata || M_WSTRB !== p_wstrb)) proto_err++;
            if (p_arv && !p_arr && (!M_ARVALID || M_ARADDR !== p_araddr)) proto_err++;
            if (p_awv && p_awr && M_AWVALID) proto_err++;
            if (p_wv && p_wr && M_WVALID) proto_err++;
            if (p_arv && p_arr && M_ARVALID) proto_err++;
            if (M_BREADY && !(aw_seen && w_seen)) proto_err++;
            if (M_RREADY && !ar_seen) proto_err++;

            if (b_pend) begin M_BVALID = 0; b_pend = 0; end
            if (aw_seen && w_seen && !M_BVALID) begin
               if (b_wait >= b_dly) begin
                  M_BVALID = 1; M_BRESP = b_resp_cfg;
                  aw_seen = 0; w_seen = 0; b_wait = 0;
               end else b_wait++;
            end
            b_pend = M_BVALID && M_BREADY;

            if (r_pend) begin M_RVALID = 0; r_pend = 0; end
            if (ar_seen && !M_RVALID) begin
               if (r_wait >= r_dly) begin
                  M_RVALID = 1; M_RDATA = r_data_cfg; M_RRESP = r_resp_cfg;
                  ar_seen = 0; r_wait = 0;
               end else r_wait++;
            end
            r_pend = M_RVALID && M_RREADY;

            M_AWREADY = M_AWVALID && (aw_wait >= aw_dly);
            aw_wait = M_AWVALID ? aw_wait + 1 : 0;
            if (M_AWVALID && M_AWREADY) begin aw_cnt++; aw_seen = 1; cap_awaddr = M_AWADDR; end

            M_WREADY = M_WVALID && (w_wait >= w_dly);
            w_wait = M_WVALID ? w_wait + 1 : 0;
            if (M_WVALID && M_WREADY) begin
               w_cnt++; w_seen = 1; cap_wdata = M_WDATA; cap_wstrb = M_WSTRB;
            end

            M_ARREADY = M_ARVALID && (ar_wait >= ar_dly);
            ar_wait = M_ARVALID ? ar_wait + 1 : 0;
            if (M_ARVALID && M_ARREADY) begin ar_cnt++; ar_seen = 1; cap_araddr = M_ARADDR; end

            p_awv = M_AWVALID; p_awr = M_AWREADY; p_awaddr = M_AWADDR;
            p_wv = M_WVALID; p_wr = M_WREADY; p_wdata = M_WDATA; p_wstrb = M_WSTRB;
            p_arv = M_ARVALID; p_arr = M_ARREADY; p_araddr = M_ARADDR;
         end
      end
   end

   task automatic set_slave(input int awd, input int wd, input int ard, input int bd, input int rd,
                            input logic [1:0] bresp, input logic [1:0] rresp, input logic [31:0] rdata);
      aw_dly = awd; w_dly = wd; ar_dly = ard; b_dly = bd; r_dly = rd;
      b_resp_cfg = bresp; r_resp_cfg = rresp; r_data_cfg = rdata;
   endtask

   // One command end to end, checked against the transaction-level expectation.
   task automatic run_txn(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input int hold);
      int          lat, busy, instab, exp_lat, aw0, w0, ar0;
      logic [31:0] exp_rdata;
      logic [1:0]  exp_resp;
      logic [34:0] snap;
      exp_rdata = we ? 32'h0 : r_data_cfg;
      exp_resp  = we ? b_resp_cfg : r_resp_cfg;
      exp_lat   = we ? 3 + ((aw_dly > w_dly) ? aw_dly : w_dly) + b_dly : 3 + ar_dly + r_dly;
      aw0 = aw_cnt; w0 = w_cnt; ar0 = ar_cnt;
      @(negedge ACLK);
      proto_err = 0;
      req_valid = 1; req_we = we; req_addr = addr; req_wdata = wdata; req_wstrb = strb;
      busy = 0;
      while (!req_ready && busy < 20) begin @(negedge ACLK); busy++; end
      chk("accept", 64'(req_ready), 64'(1));
      @(negedge ACLK);
      req_valid = 0; req_addr = $urandom; req_wdata = $urandom; req_wstrb = 4'($urandom);
      lat = 1;
      while (!rsp_valid && lat < 60) begin @(negedge ACLK); lat++; end
      chk("latency", 64'(lat), 64'(exp_lat));
      snap = {rsp_rdata, rsp_resp, rsp_we};
      instab = 0;
      for (int i = 0; i < hold; i++) begin
         @(negedge ACLK);
         if ({rsp_rdata, rsp_resp, rsp_we} !== snap || !rsp_valid || req_ready) instab++;
      end
      if (hold > 0) chk("rsp_hold_stable", 64'(instab), 64'(0));
      chk("rsp_rdata", 64'(rsp_rdata), 64'(exp_rdata));
      chk("rsp_resp", 64'(rsp_resp), 64'(exp_resp));
      chk("rsp_we", 64'(rsp_we), 64'(we));
      rsp_ready = 1;
      @(negedge ACLK);
      rsp_ready = 0;
      chk("next_accept_ready", 64'({req_ready, rsp_valid}), 64'(2'b10));
      chk("aw_handshakes", 64'(aw_cnt - aw0), 64'(we));
      chk("w_handshakes", 64'(w_cnt - w0), 64'(we));
      chk("ar_handshakes", 64'(ar_cnt - ar0), 64'(!we));
      if (we) begin
         chk("awaddr", 64'(cap_awaddr), 64'(addr));
         chk("wdata", 64'(cap_wdata), 64'(wdata));
         chk("wstrb", 64'(cap_wstrb), 64'(strb));
      end else begin
         chk("araddr", 64'(cap_araddr), 64'(addr));
      end
      chk("protocol", 64'(proto_err), 64'(0));
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
      $fatal(1);
   end

   initial begin : main
      ARESET = 1; slv_rst = 1;
      req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0; rsp_ready = 0;
      set_slave(0, 0, 0, 0, 0, RESP_OKAY, RESP_OKAY, 32'h0);
      repeat (3) @(negedge ACLK);
      chk("rst_req_ready", 64'(req_ready), 64'(1));
      chk("rst_valids", 64'({M_AWVALID, M_WVALID, M_ARVALID, rsp_valid}), 64'(0));
      chk("rst_rsp", 64'({rsp_rdata, rsp_resp, rsp_we}), 64'(0));
      chk("rst_axi_payload", 64'({M_AWADDR, M_WDATA}), 64'(0));
      chk("rst_araddr_wstrb", 64'({M_ARADDR, M_WSTRB}), 64'(0));
      ARESET = 0; slv_rst = 0;

      // zero-wait write
      run_txn(1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
      // staggered handshakes, both orders
      set_slave(0, 2, 0, 0, 0, RESP_OKAY, RESP_OKAY, 32'h0);
      run_txn(1, 32'h24, 32'hA5A5_0001, 4'h3, 0);
      set_slave(2, 0, 0, 1, 0, RESP_DECERR, RESP_OKAY, 32'h0);
      run_txn(1, 32'h33, 32'h0BAD_F00D, 4'h0, 0);
      // stalled read with SLVERR
      set_slave(0, 0, 3, 0, 0, RESP_OKAY, RESP_SLVERR, 32'h12345678);
      run_txn(0, 32'h20, 32'hFFFF_FFFF, 4'hF, 0);
      // response backpressure
      set_slave(0, 0, 0, 0, 1, RESP_OKAY, RESP_EXOKAY, 32'hCAFE_0042);
      run_txn(0, 32'h41, 32'h0, 4'h0, 4);

      // reset in the middle of a write while AW is stalled
      set_slave(5, 5, 0, 0, 0, RESP_OKAY, RESP_OKAY, 32'h0);
      @(negedge ACLK);
      req_valid = 1; req_we = 1; req_addr = 32'h80; req_wdata = 32'h1; req_wstrb = 4'hF;
      @(negedge ACLK);
      req_valid = 0;
      chk("awvalid_before_rst", 64'(M_AWVALID), 64'(1));
      ARESET = 1; slv_rst = 1;
      @(negedge ACLK);
      ARESET = 0;
      chk("midrst_valids", 64'({M_AWVALID, M_WVALID, M_ARVALID, rsp_valid}), 64'(0));
      chk("midrst_req_ready", 64'(req_ready), 64'(1));
      @(negedge ACLK);
      slv_rst = 0;
      set_slave(0, 0, 0, 0, 0, RESP_OKAY, RESP_OKAY, 32'h5555_AAAA);
      run_txn(0, 32'h84, 32'h0, 4'h0, 0);

      // randomized traffic
      for (int k = 0; k < 40; k++) begin
         set_slave(int'($urandom_range(3, 0)), int'($urandom_range(3, 0)), int'($urandom_range(3, 0)),
                   int'($urandom_range(2, 0)), int'($urandom_range(2, 0)),
                   2'($urandom), 2'($urandom), $urandom);
         run_txn(1'($urandom), $urandom, $urandom, 4'($urandom), int'($urandom_range(3, 0)));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
